// File: rtl/mem_stage.sv
// Y86-64 memory-access stage: decodes M_icode, runs a req/ack data-memory access and stalls the pipe while it is open.
// Optional MEM_STAGE_ALIGN_CHECK_EN: misaligned qualified accesses report SADR without touching the bus.
module mem_stage #(
  parameter int MEM_BYTES   = 65536,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [3:0]  M_stat_i,
  input  logic [3:0]  M_icode_i,
  input  logic [63:0] M_valE_i,
  input  logic [63:0] M_valA_i,
  input  logic        dmem_ack_i,
  input  logic        dmem_err_i,
  input  logic [63:0] dmem_rdata_i,
  output logic        dmem_req_o,
  output logic        dmem_we_o,
  output logic [63:0] dmem_addr_o,
  output logic [63:0] dmem_wdata_o,
  output logic [63:0] m_valM_o,
  output logic [3:0]  m_stat_o,
  output logic        m_stall_o
);

  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [3:0] SAOK = 4'd1;
  localparam logic [3:0] SADR = 4'd3;

  localparam logic [63:0] ADDR_MAX = 64'(MEM_BYTES - 8);
  localparam logic [7:0]  TO_MAX   = 8'(TIMEOUT_CYC);

  typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

  state_t      state;
  logic [7:0]  to_cnt;
  logic        err_q;

  logic        is_read;
  logic        is_write;
  logic        is_mem;
  logic [63:0] addr;
  logic        in_range;
  logic        misaligned;
  logic        qualified;

  always_comb begin
    is_read  = (M_icode_i == I_MRMOVQ) || (M_icode_i == I_POPQ) || (M_icode_i == I_RET);
    is_write = (M_icode_i == I_RMMOVQ) || (M_icode_i == I_PUSHQ) || (M_icode_i == I_CALL);
    is_mem   = is_read || is_write;
    addr     = ((M_icode_i == I_POPQ) || (M_icode_i == I_RET)) ? M_valA_i : M_valE_i;
    in_range = (addr <= ADDR_MAX);
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    misaligned = (addr[2:0] != 3'd0);
`else
    misaligned = 1'b0;
`endif
    qualified = is_mem && (M_stat_i == SAOK) && in_range && !misaligned;
  end

  // Stall covers the launching IDLE cycle and every REQ cycle; DONE lets M advance.
  always_comb begin
    m_stall_o = ((state == IDLE) && qualified) || (state == REQ);
  end

  always_comb begin
    m_stat_o = M_stat_i;
    if (M_stat_i != SAOK)
      m_stat_o = M_stat_i;
    else if (is_mem && (!in_range || misaligned))
      m_stat_o = SADR;
    else if ((state == DONE) && err_q)
      m_stat_o = SADR;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      to_cnt       <= 8'd0;
      err_q        <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= 64'd0;
      dmem_wdata_o <= 64'd0;
      m_valM_o     <= 64'd0;
    end else begin
      case (state)
        IDLE: begin
          if (qualified) begin
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= is_write;
            dmem_addr_o  <= addr;
            dmem_wdata_o <= M_valA_i;
            to_cnt       <= 8'd0;
            state        <= REQ;
          end
        end
        REQ: begin
          // Ack takes priority over a timeout landing in the same cycle.
          if (dmem_ack_i) begin
            dmem_req_o <= 1'b0;
            err_q      <= dmem_err_i;
            m_valM_o   <= (!dmem_err_i && !dmem_we_o) ? dmem_rdata_i : 64'd0;
            state      <= DONE;
          end else if (to_cnt == TO_MAX) begin
            dmem_req_o <= 1'b0;
            err_q      <= 1'b1;
            m_valM_o   <= 64'd0;
            state      <= DONE;
          end else begin
            to_cnt <= to_cnt + 8'd1;
          end
        end
        DONE: begin
          err_q  <= 1'b0;
          to_cnt <= 8'd0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: per-op expectations queued on issue, checked when M releases.
module tb_mem_stage;

  localparam int MEM_BYTES   = 65536;
  localparam int TIMEOUT_CYC = 255;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [3:0]  M_stat_i;
  logic [3:0]  M_icode_i;
  logic [63:0] M_valE_i;
  logic [63:0] M_valA_i;
  logic        dmem_ack_i;
  logic        dmem_err_i;
  logic [63:0] dmem_rdata_i;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [63:0] dmem_wdata_o;
  logic [63:0] m_valM_o;
  logic [3:0]  m_stat_o;
  logic        m_stall_o;

  int tests = 0;
  int fails = 0;

  typedef struct {
    string       tag;
    logic [3:0]  stat;
    logic [63:0] valM;
    int          stall;
    int          reqs;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] model_valM;

  always #5 clk_i = ~clk_i;

  mem_stage #(.MEM_BYTES(MEM_BYTES), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .M_stat_i(M_stat_i), .M_icode_i(M_icode_i), .M_valE_i(M_valE_i), .M_valA_i(M_valA_i),
    .dmem_ack_i(dmem_ack_i), .dmem_err_i(dmem_err_i), .dmem_rdata_i(dmem_rdata_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .m_valM_o(m_valM_o), .m_stat_o(m_stat_o), .m_stall_o(m_stall_o)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one instruction into M, play the memory side, check when the stall drops.
  task automatic run_op(input string tag, input logic [3:0] icode, input logic [3:0] stat,
                        input logic [63:0] valE, input logic [63:0] valA,
                        input int ack_after, input logic err, input logic [63:0] rdata);
    logic        rd, wr, mem, inr, qual, mis;
    logic [63:0] a;
    exp_t        e, got;
    int          stall_cnt, req_cnt;
    bit          done, first_req;
    rd  = (icode == 4'h5) || (icode == 4'hB) || (icode == 4'h9);
    wr  = (icode == 4'h4) || (icode == 4'hA) || (icode == 4'h8);
    mem = rd || wr;
    a   = ((icode == 4'hB) || (icode == 4'h9)) ? valA : valE;
    inr = (a <= 64'(MEM_BYTES - 8));
`ifdef MEM_STAGE_ALIGN_CHECK_EN
    mis = (a[2:0] != 3'd0);
`else
    mis = 1'b0;
`endif
    qual = mem && (stat == 4'd1) && inr && !mis;
    e.tag = tag;
    if (!qual) begin
      e.stall = 0;
      e.reqs  = 0;
      e.stat  = (stat != 4'd1) ? stat : ((mem && (!inr || mis)) ? 4'd3 : stat);
      e.valM  = model_valM;
    end else if (ack_after < 0 || ack_after > TIMEOUT_CYC) begin
      e.reqs  = TIMEOUT_CYC + 1;
      e.stall = e.reqs + 1;
      e.stat  = 4'd3;
      e.valM  = 64'd0;
    end else begin
      e.reqs  = ack_after + 1;
      e.stall = e.reqs + 1;
      e.stat  = err ? 4'd3 : 4'd1;
      e.valM  = (err || wr) ? 64'd0 : rdata;
    end
    model_valM = e.valM;
    sb.push_back(e);

    M_icode_i = icode; M_stat_i = stat; M_valE_i = valE; M_valA_i = valA;
    dmem_ack_i = 1'b0;
    stall_cnt = 0; req_cnt = 0; done = 0; first_req = 1;
    for (int cyc = 0; cyc < 600 && !done; cyc++) begin
      if (dmem_req_o) begin
        req_cnt++;
        if (first_req) begin
          first_req = 0;
          chk({tag, " addr"},  dmem_addr_o, a);
          chk({tag, " we"},    {63'd0, dmem_we_o}, {63'd0, wr});
          if (wr) chk({tag, " wdata"}, dmem_wdata_o, valA);
        end
        dmem_ack_i   = (ack_after >= 0) && (req_cnt == ack_after + 1);
        dmem_err_i   = err;
        dmem_rdata_i = rdata;
      end else begin
        dmem_ack_i = 1'b0;
      end
      #1;
      if (m_stall_o) begin
        stall_cnt++;
      end else begin
        done = 1;
        if (sb.size() == 0) begin
          chk({tag, " sb_empty"}, 64'd1, 64'd0);
        end else begin
          got = sb.pop_front();
          chk({got.tag, " stat"},  {60'd0, m_stat_o}, {60'd0, got.stat});
          chk({got.tag, " valM"},  m_valM_o, got.valM);
          chk({got.tag, " stall"}, 64'(stall_cnt), 64'(got.stall));
          chk({got.tag, " reqs"},  64'(req_cnt), 64'(got.reqs));
        end
      end
      @(posedge clk_i); #1;
    end
    dmem_ack_i = 1'b0;
    if (!done) chk({tag, " timeout"}, 64'd0, 64'd1);
  endtask

  initial begin
    rst_i = 1'b1;
    M_stat_i = 4'd1; M_icode_i = 4'h1; M_valE_i = 64'd0; M_valA_i = 64'd0;
    dmem_ack_i = 1'b0; dmem_err_i = 1'b0; dmem_rdata_i = 64'd0;
    model_valM = 64'd0;
    repeat (2) @(posedge clk_i);
    #1;
    chk("rst req",   {63'd0, dmem_req_o}, 64'd0);
    chk("rst we",    {63'd0, dmem_we_o}, 64'd0);
    chk("rst addr",  dmem_addr_o, 64'd0);
    chk("rst wdata", dmem_wdata_o, 64'd0);
    chk("rst valM",  m_valM_o, 64'd0);
    chk("rst stall", {63'd0, m_stall_o}, 64'd0);
    chk("rst stat",  {60'd0, m_stat_o}, 64'd1);
    rst_i = 1'b0;
    @(posedge clk_i); #1;

    run_op("mrmovq",        4'h5, 4'd1, 64'h100,  64'h0,    2,  1'b0, 64'hDEAD);
    run_op("popq_oor",      4'hB, 4'd1, 64'h0,    64'(MEM_BYTES), 0, 1'b0, 64'h0);
    run_op("pushq",         4'hA, 4'd1, 64'h1F8,  64'h55,   0,  1'b0, 64'hBAD);
    run_op("mrmovq_sins",   4'h5, 4'd4, 64'h100,  64'h0,    0,  1'b0, 64'h0);
    run_op("ret_err",       4'h9, 4'd1, 64'h0,    64'h200,  1,  1'b1, 64'h77);
    run_op("addq",          4'h6, 4'd1, 64'h1234, 64'h5,    0,  1'b0, 64'h0);
    run_op("pushq_edge",    4'hA, 4'd1, 64'(MEM_BYTES - 8), 64'h99, 0, 1'b0, 64'h0);
    run_op("rmmovq_oor",    4'h4, 4'd1, 64'(MEM_BYTES - 7), 64'h1, 0, 1'b0, 64'h0);
    run_op("rmmovq_to",     4'h4, 4'd1, 64'h300,  64'hAB,   -1, 1'b0, 64'h0);
    run_op("mrmovq_unal",   4'h5, 4'd1, 64'h103,  64'h0,    0,  1'b0, 64'h1234);
    run_op("mrmovq_prerst", 4'h5, 4'd1, 64'h108,  64'h0,    0,  1'b0, 64'hCAFE);

    // Abandon an open read with a reset in its third REQ cycle.
    M_icode_i = 4'h5; M_stat_i = 4'd1; M_valE_i = 64'h110; M_valA_i = 64'd0;
    dmem_ack_i = 1'b0;
    repeat (3) begin @(posedge clk_i); #1; end
    chk("midrst req_before", {63'd0, dmem_req_o}, 64'd1);
    rst_i = 1'b1; M_icode_i = 4'h0; M_stat_i = 4'd2;
    @(posedge clk_i); #1;
    chk("midrst req",   {63'd0, dmem_req_o}, 64'd0);
    chk("midrst stall", {63'd0, m_stall_o}, 64'd0);
    chk("midrst valM",  m_valM_o, 64'd0);
    chk("midrst stat",  {60'd0, m_stat_o}, 64'd2);
    rst_i = 1'b0;
    @(posedge clk_i); #1;
    chk("postrst req",  {63'd0, dmem_req_o}, 64'd0);
    chk("postrst stat", {60'd0, m_stat_o}, 64'd2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
